// File: rtl/id_ex_hazard_reg_pkg.sv
// riscv_pkg: definitions shared by the ID/EX pipeline register and its
// load-use detector.
//   CTRL_W     - width of the packed control word carried from D to E
//   CTRL_*     - bit offsets of each control field inside that word
//   ctrl_t     - typed view of the control word (MSB first: reg_write ... alu_op)
//   CTRL_BUBBLE- control word of a bubble (all fields inactive)
package riscv_pkg;

  localparam int REG_IDX_W = 5;
  localparam int CTRL_W    = 11;

  localparam int CTRL_REG_WRITE  = 10;
  localparam int CTRL_MEM_READ   = 9;
  localparam int CTRL_MEM_WRITE  = 8;
  localparam int CTRL_MEM_TO_REG = 7;
  localparam int CTRL_ALU_SRC    = 6;
  localparam int CTRL_BRANCH     = 5;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_ALU_OP_LSB = 0;
  localparam int CTRL_ALU_OP_W   = 4;

  // Field order matches the offsets above: the first member is the MSB.
  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_hazard_reg_load_use_detect.sv
// load_use_detect: combinational load-use hazard detector.
// Flags when the instruction in E is a valid load writing a non-zero
// register that the valid instruction in D actually reads.
//   valid_E, mem_read_E, rd_E     - state of the instruction in E
//   valid_D, rs1_D, rs2_D,
//   use_rs1_D, use_rs2_D          - source operands of the instruction in D
//   lu                            - hazard present (D must wait one cycle)
module load_use_detect
  import riscv_pkg::*;
(
  input  logic                 valid_E,
  input  logic                 mem_read_E,
  input  logic [REG_IDX_W-1:0] rd_E,
  input  logic                 valid_D,
  input  logic [REG_IDX_W-1:0] rs1_D,
  input  logic [REG_IDX_W-1:0] rs2_D,
  input  logic                 use_rs1_D,
  input  logic                 use_rs2_D,
  output logic                 lu
);

  logic [1:0][REG_IDX_W-1:0] rs;
  logic [1:0]                use_rs;
  logic [1:0]                hit;

  assign rs     = {rs2_D, rs1_D};
  assign use_rs = {use_rs2_D, use_rs1_D};

  // Only a source the instruction really reads can create a dependency;
  // an unused rs field may hold arbitrary encoding bits.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    assign hit[gi] = use_rs[gi] & (rs[gi] == rd_E);
  end

  // x0 is hard-wired zero, so a load targeting it never needs waiting on.
  assign lu = valid_E & mem_read_E & (rd_E != '0) & valid_D & (|hit);

endmodule

// File: rtl/id_ex_hazard_reg.sv
// id_ex_hazard_reg: ID/EX pipeline register with load-use stall, bubble
// insertion on load-use hazards and taken-branch flushes, and a global hold.
//   clk, rst_n        - clock (rising edge), asynchronous active-low reset
//   *_D inputs        - decoded instruction state from the D stage
//   hold              - freeze everything (data-memory wait)
//   flush             - taken branch/jump resolved in EX; kill the D slot
//   *_E outputs       - registered E-stage operands, indices and control
//   stall_D           - combinational: freeze PC and IF/ID
//   bubble_cnt        - saturating count of bubbles inserted
module id_ex_hazard_reg
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_D,
  input  logic [XLEN-1:0]      pc_D,
  input  logic [REG_IDX_W-1:0] rs1_D,
  input  logic [REG_IDX_W-1:0] rs2_D,
  input  logic [REG_IDX_W-1:0] rd_D,
  input  logic                 use_rs1_D,
  input  logic                 use_rs2_D,
  input  logic [XLEN-1:0]      rs1_data_D,
  input  logic [XLEN-1:0]      rs2_data_D,
  input  logic [XLEN-1:0]      imm_D,
  input  logic [CTRL_W-1:0]    ctrl_D,
  input  logic                 hold,
  input  logic                 flush,
  output logic                 valid_E,
  output logic [XLEN-1:0]      pc_E,
  output logic [XLEN-1:0]      rs1_data_E,
  output logic [XLEN-1:0]      rs2_data_E,
  output logic [XLEN-1:0]      imm_E,
  output logic [REG_IDX_W-1:0] rs1_E,
  output logic [REG_IDX_W-1:0] rs2_E,
  output logic [REG_IDX_W-1:0] rd_E,
  output logic [CTRL_W-1:0]    ctrl_E,
  output logic                 stall_D,
  output logic [CNT_W-1:0]     bubble_cnt
);

  logic             lu;
  logic             flush_pending_reg;
  logic             take_bubble;
  logic [CNT_W-1:0] bubble_cnt_reg;
  logic [CNT_W-1:0] bubble_cnt_next;

  load_use_detect u_load_use_detect (
    .valid_E    (valid_E),
    .mem_read_E (ctrl_E[CTRL_MEM_READ]),
    .rd_E       (rd_E),
    .valid_D    (valid_D),
    .rs1_D      (rs1_D),
    .rs2_D      (rs2_D),
    .use_rs1_D  (use_rs1_D),
    .use_rs2_D  (use_rs2_D),
    .lu         (lu)
  );

  // A flush (live or remembered across a hold) kills the D instruction
  // anyway, so a load-use hazard on it must not stall the front end.
  assign stall_D = hold | (lu & ~flush & ~flush_pending_reg);

  always_comb begin
    take_bubble     = ~hold & (flush | flush_pending_reg | lu);
    bubble_cnt_next = bubble_cnt_reg;
    if (take_bubble && (bubble_cnt_reg != '1)) begin
      bubble_cnt_next = bubble_cnt_reg + CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_E           <= 1'b0;
      pc_E              <= '0;
      rs1_data_E        <= '0;
      rs2_data_E        <= '0;
      imm_E             <= '0;
      rs1_E             <= '0;
      rs2_E             <= '0;
      rd_E              <= '0;
      ctrl_E            <= '0;
      flush_pending_reg <= 1'b0;
      bubble_cnt_reg    <= '0;
    end else begin
      bubble_cnt_reg <= bubble_cnt_next;
      if (hold) begin
        // E contents frozen; a flush seen now is applied once hold drops.
        if (flush) begin
          flush_pending_reg <= 1'b1;
        end
      end else if (take_bubble) begin
        valid_E           <= 1'b0;
        pc_E              <= '0;
        rs1_data_E        <= '0;
        rs2_data_E        <= '0;
        imm_E             <= '0;
        rs1_E             <= '0;
        rs2_E             <= '0;
        rd_E              <= '0;
        ctrl_E            <= CTRL_BUBBLE;
        flush_pending_reg <= 1'b0;
      end else begin
        valid_E    <= valid_D;
        pc_E       <= pc_D;
        rs1_data_E <= rs1_data_D;
        rs2_data_E <= rs2_data_D;
        imm_E      <= imm_D;
        rs1_E      <= rs1_D;
        rs2_E      <= rs2_D;
        // An empty D slot must not write a register or trigger a hazard.
        rd_E       <= valid_D ? rd_D : '0;
        ctrl_E     <= valid_D ? ctrl_D : CTRL_BUBBLE;
      end
    end
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures decoded instruction state each cycle and presents the E-stage operands and control. rs1_E/rs2_E feed the forwarding unit directly. It generates the decode stall, inserts bubbles on load-use hazards and taken-branch flushes, and honours a global memory hold.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, bubble counter width

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
valid_D  in  1  decode slot holds a real instruction
pc_D  in  XLEN  decode PC
rs1_D  in  5  source register 1 index
rs2_D  in  5  source register 2 index
rd_D  in  5  destination index
use_rs1_D  in  1  instruction reads rs1
use_rs2_D  in  1  instruction reads rs2
rs1_data_D  in  XLEN  register file read 1
rs2_data_D  in  XLEN  register file read 2
imm_D  in  XLEN  decoded immediate
ctrl_D  in  CTRL_W  packed control word (package layout)
hold  in  1  global freeze (data-memory wait)
flush  in  1  taken branch/jump resolved in EX
valid_E  out  1  E slot valid
pc_E, rs1_data_E, rs2_data_E, imm_E  out  XLEN each  registered copies
rs1_E, rs2_E, rd_E  out  5 each  registered indices (to forwarding unit)
ctrl_E  out  CTRL_W  registered control; all-zero when bubble
stall_D  out  1  freeze PC and IF/ID
bubble_cnt  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (rst_n=0, async): valid_E=0, every E output=0, flush_pending=0, bubble_cnt=0. Deassertion is used synchronously, with no extra cycle.
- Register outputs have 1-cycle latency from D inputs. stall_D is combinational.
- Load-use hazard, lu: valid_E & ctrl_E.memRead & rd_E!=0 & valid_D & ((use_rs1_D & rs1_D==rd_E) | (use_rs2_D & rs2_D==rd_E)).
- stall_D = hold | (lu & ~flush & ~flush_pending).
- Per-edge priority, highest first:
  1. hold=1: all E registers keep their value. If flush=1, set flush_pending.
  2. flush | flush_pending: load a bubble and clear flush_pending.
  3. lu: load a bubble.
  4. Otherwise load the D inputs. valid_E takes valid_D.
- Bubble: valid_E=0, ctrl_E=0, rd_E=0, rs1_E=0, rs2_E=0. Data fields are don't-care but are driven to 0.
- An invalid D slot (valid_D=0) also loads ctrl_E=0, rd_E=0.
- bubble_cnt increments by 1 on every edge where rule 2 or rule 3 fires. It saturates at all-ones and does not wrap.
- Simultaneous flush and lu: flush wins, stall_D=0, one bubble is inserted, and bubble_cnt increments by 1.
- flush on consecutive cycles inserts one bubble per edge.
- hold asserted mid-hazard: stall_D stays 1 and the E contents are preserved. lu is re-evaluated after hold drops.
- x0 as rd_E never causes a stall.

Decomposition:
- Package riscv_pkg holds:
  - CTRL_W=11.
  - Field offsets: regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp[3:0].
  - A typed ctrl_t struct and the CTRL_BUBBLE constant.
- One sub-module, load_use_detect, is combinational. It takes E memRead/rd/valid plus D rs/use/valid and outputs lu. The top level holds the registers, flush_pending and the counter.

Test Plan:
1. Reset then ADD x3,x1,x2 with valid_D=1 -> next edge: valid_E=1, rs1_E=1, rs2_E=2, rd_E=3, ctrl_E=ctrl_D, stall_D=0.
2. LW x5 in E (memRead=1), then D = ADD x6,x5,x7 -> stall_D=1. Next edge: valid_E=0, ctrl_E=0, bubble_cnt=1. The following edge loads the ADD with stall_D=0.
3. LW x0 in E, D reads x0 -> stall_D=0, no bubble. LW x5 in E with D use_rs2_D=0 and rs2_D=5 -> no stall.
4. flush=1 with lu=1 on the same cycle -> stall_D=0, one bubble, bubble_cnt increments by 1.
5. hold=1 for 3 cycles with flush pulsed in cycle 1 -> E frozen, stall_D=1 throughout. The first edge after hold drops loads a bubble and flush_pending=0.
6. Preload bubble_cnt near max (force to all-ones minus 1) and insert 3 bubbles -> counter ends at all-ones. Assert rst_n low mid-stream -> all outputs 0 immediately, without waiting for a clock.
